down_counter_ctrl: RTL and testbench



---
 rtl/down_counter_pkg.sv | 12 +
 rtl/down_counter_ctrl.sv | 89 ++++++++
 tb/tb_down_counter_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the loadable down-counter used by the conv1d control path.
package down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEFAULT = 8;

endpackage : down_counter_pkg

// File: rtl/down_counter_ctrl.sv
// Loadable down-counter with start/done handshake: a RUN pass lasts load_value+1 enabled
// cycles, ends with a one-cycle terminal_count and a done level held until done_ack.
module down_counter_ctrl
    import down_counter_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] load_value,
    input  logic         enable,
    input  logic         abort,
    input  logic         done_ack,
    output logic         busy,
    output logic [N-1:0] count,
    output logic         terminal_count,
    output logic         done
);

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic         terminal_count_q, terminal_count_d;

    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        terminal_count_d = 1'b0;

        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    count_d = '0;
                    if (start) begin
                        count_d = load_value;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // The zero cycle is itself an enabled cycle, giving load_value+1 in total.
                    if (enable) begin
                        if (count_q != '0) begin
                            count_d = count_q - N'(1);
                        end else begin
                            terminal_count_d = 1'b1;
                            state_d          = DONE;
                        end
                    end
                end
                DONE: begin
                    count_d = '0;
                    if (done_ack) begin
                        if (start) begin
                            count_d = load_value;
                            state_d = RUN;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            count_q          <= '0;
            terminal_count_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            terminal_count_q <= terminal_count_d;
        end
    end

    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign count          = count_q;
    assign terminal_count = terminal_count_q;

endmodule : down_counter_ctrl

// File: tb/tb_down_counter_ctrl.sv
// Directed and randomized checks of down_counter_ctrl against a cycle-count reference model.
module tb_down_counter_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] load_value;
    logic         enable;
    logic         abort;
    logic         done_ack;
    logic         busy;
    logic [N-1:0] count;
    logic         terminal_count;
    logic         done;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0=idle 1=running 2=finished; a run of length L finishes on
    // its (L+1)-th enabled cycle, and the visible count is L minus enabled cycles consumed.
    int m_phase = 0;
    int m_len   = 0;
    int m_used  = 0;
    bit m_tc    = 1'b0;

    down_counter_ctrl #(.N(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .load_value     (load_value),
        .enable         (enable),
        .abort          (abort),
        .done_ack       (done_ack),
        .busy           (busy),
        .count          (count),
        .terminal_count (terminal_count),
        .done           (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_len   = 0;
        m_used  = 0;
        m_tc    = 1'b0;
    endtask

    task automatic model_clock(input bit s, input int lv, input bit en, input bit ab, input bit ack);
        bit tc_next;
        tc_next = 1'b0;
        if (ab) begin
            m_phase = 0;
            m_len   = 0;
            m_used  = 0;
        end else if (m_phase == 0) begin
            if (s) begin
                m_phase = 1;
                m_len   = lv;
                m_used  = 0;
            end
        end else if (m_phase == 1) begin
            if (en) begin
                if (m_used == m_len) begin
                    m_phase = 2;
                    tc_next = 1'b1;
                end else begin
                    m_used++;
                end
            end
        end else begin
            if (ack) begin
                if (s) begin
                    m_phase = 1;
                    m_len   = lv;
                    m_used  = 0;
                end else begin
                    m_phase = 0;
                end
            end
        end
        m_tc = tc_next;
    endtask

    task automatic check_all(input string tag);
        int exp_count;
        exp_count = (m_phase == 1) ? (m_len - m_used) : 0;
        chk({tag, ".busy"},  32'(busy),           32'(m_phase == 1));
        chk({tag, ".count"}, 32'(count),          32'(exp_count));
        chk({tag, ".tc"},    32'(terminal_count), 32'(m_tc));
        chk({tag, ".done"},  32'(done),           32'(m_phase == 2));
    endtask

    // Drive one cycle of inputs, clock, advance the model, check 1 time unit after the edge.
    task automatic step(input string tag, input bit s, input int lv, input bit en,
                        input bit ab, input bit ack);
        start      = s;
        load_value = N'(lv);
        enable     = en;
        abort      = ab;
        done_ack   = ack;
        @(posedge clk);
        model_clock(s, lv, en, ab, ack);
        #1;
        check_all(tag);
    endtask

    // Clock with start low until terminal_count is seen; mode 0 holds enable high,
    // mode 1 uses the repeating pattern 1,0,0. Returns enabled cycles consumed.
    task automatic run_to_tc(input string tag, input int mode, input int max_cycles,
                             output int en_cycles, output int tc_pulses);
        bit en;
        en_cycles = 0;
        tc_pulses = 0;
        for (int i = 0; i < max_cycles; i++) begin
            en = (mode == 0) ? 1'b1 : ((i % 3) == 0);
            step(tag, 1'b0, 0, en, 1'b0, 1'b0);
            if (en) en_cycles++;
            if (terminal_count === 1'b1) begin
                tc_pulses++;
                break;
            end
        end
    endtask

    initial begin
        int en_cycles;
        int tc_pulses;
        int seen_tc;

        reset = 1'b1;
        start = 1'b0; load_value = '0; enable = 1'b0; abort = 1'b0; done_ack = 1'b0;
        #12;
        check_all("reset");
        #5 reset = 1'b0;

        // Length 3 with enable held high; done held while unacknowledged.
        step("l3_start", 1'b1, 3, 1'b1, 1'b0, 1'b0);
        chk("l3_count_loaded", 32'(count), 32'd3);
        run_to_tc("l3_run", 0, 20, en_cycles, tc_pulses);
        chk("l3_enabled_cycles", 32'(en_cycles), 32'd4);
        chk("l3_tc_pulses", 32'(tc_pulses), 32'd1);
        step("l3_hold", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        step("l3_start_no_ack", 1'b1, 7, 1'b1, 1'b0, 1'b0);
        chk("l3_done_held", 32'(done), 32'd1);
        step("l3_ack", 1'b0, 0, 1'b0, 1'b0, 1'b1);
        step("l3_idle", 1'b0, 0, 1'b1, 1'b0, 1'b1);

        // Boundary lengths.
        step("l0_start", 1'b1, 0, 1'b0, 1'b0, 1'b0);
        run_to_tc("l0_run", 0, 10, en_cycles, tc_pulses);
        chk("l0_enabled_cycles", 32'(en_cycles), 32'd1);
        step("l0_ack", 1'b0, 0, 1'b0, 1'b0, 1'b1);
        step("l255_start", 1'b1, 255, 1'b1, 1'b0, 1'b0);
        run_to_tc("l255_run", 0, 300, en_cycles, tc_pulses);
        chk("l255_enabled_cycles", 32'(en_cycles), 32'd256);
        step("l255_no_wrap", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("l255_count_zero", 32'(count), 32'd0);
        step("l255_ack", 1'b0, 0, 1'b1, 1'b0, 1'b1);

        // Paused counting.
        step("l5_start", 1'b1, 5, 1'b0, 1'b0, 1'b0);
        run_to_tc("l5_pause", 1, 40, en_cycles, tc_pulses);
        chk("l5_enabled_cycles", 32'(en_cycles), 32'd6);
        step("l5_ack", 1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Abort in RUN at count 2, then abort in DONE, then a normal run.
        step("ab_start", 1'b1, 6, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("ab_run", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("ab_count_before", 32'(count), 32'd2);
        step("ab_run_abort", 1'b1, 9, 1'b1, 1'b1, 1'b0);
        chk("ab_run_idle_count", 32'(count), 32'd0);
        step("ab_start2", 1'b1, 1, 1'b1, 1'b0, 1'b0);
        run_to_tc("ab_run2", 0, 10, en_cycles, tc_pulses);
        step("ab_done_abort", 1'b1, 4, 1'b1, 1'b1, 1'b1);
        chk("ab_done_cleared", 32'(done), 32'd0);
        step("ab_start3", 1'b1, 2, 1'b1, 1'b0, 1'b0);
        run_to_tc("ab_run3", 0, 10, en_cycles, tc_pulses);
        chk("ab_run3_cycles", 32'(en_cycles), 32'd3);

        // Back-to-back restart from DONE; start in RUN ignored.
        step("b2b_restart", 1'b1, 4, 1'b1, 1'b0, 1'b1);
        chk("b2b_count", 32'(count), 32'd4);
        step("b2b_ignore_start", 1'b1, 9, 1'b1, 1'b0, 1'b0);
        chk("b2b_count_continues", 32'(count), 32'd3);
        run_to_tc("b2b_run", 0, 10, en_cycles, tc_pulses);
        chk("b2b_enabled_cycles", 32'(en_cycles), 32'd4);
        step("b2b_ack", 1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(3) == 0),
                 ($urandom_range(7) == 0) ? int'($urandom_range(255)) : int'($urandom_range(12)),
                 ($urandom_range(3) != 0),
                 ($urandom_range(24) == 0),
                 ($urandom_range(2) == 0));
        end

        // Asynchronous reset between edges in the middle of a run.
        step("ar_idle", 1'b0, 0, 1'b0, 1'b1, 1'b0);
        step("ar_start", 1'b1, 10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("ar_run", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("ar_immediate");
        @(posedge clk);
        #1;
        check_all("ar_held");
        #3 reset = 1'b0;
        seen_tc = 0;
        for (int i = 0; i < 15; i++) begin
            step("ar_after", 1'b0, 0, 1'b1, 1'b0, 1'b0);
            if (terminal_count !== 1'b0 || done !== 1'b0) seen_tc++;
        end
        chk("ar_no_spurious", 32'(seen_tc), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_down_counter_ctrl
